// File: rtl/gopf_poly_mul_ctrl.sv
// ----------------------------------------------------------------------------
// gopf_poly_mul_ctrl
//
// Controller for C = A*B mod g(x) (optionally XOR an accumulate operand) over
// polynomials of N coefficients in GF(2^W), with g monic of degree N. B is
// consumed Horner-style, MSB coefficient first. The controller never
// multiplies coefficients itself. Every scalar product is requested from an
// external coefficient MAC array as a pass of the form res = s*v XOR add.
//
// Ports
//   clk, rst_b        clock (rising edge); asynchronous active-low reset
//   start, acc_en     request and accumulate select (sampled only in IDLE)
//   multiplicand      A, coefficient k at [k*W +: W]
//   multiplier        B, same packing
//   mod               g(x) without its x^N term
//   acc_in            accumulate operand
//   mul_out           result, valid from the FIN cycle until the next accept
//   mul_done          one-cycle pulse in FIN
//   busy              high whenever the FSM is not in IDLE
//   arr_req           one-cycle pass request to the MAC array
//   arr_s/v/add       pass operands, held from arr_req until the capture edge
//   arr_res           arr_s*arr_v XOR arr_add, valid LAT cycles after arr_req
//   dbg_state_o       current FSM state (debug)
//
// Handshake: start is accepted only on a rising edge where the FSM is in IDLE
// (busy = 0). The run ends with mul_done high for exactly one cycle. For the
// array, arr_req is high for one cycle per pass with no back-pressure. The
// result is captured on the edge that ends the LAT-th cycle after arr_req.
// ----------------------------------------------------------------------------
module gopf_poly_mul_ctrl #(
    parameter int N   = 9,
    parameter int W   = 16,
    parameter int LAT = 1
) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic           start,
    input  logic           acc_en,
    input  logic [N*W-1:0] multiplicand,
    input  logic [N*W-1:0] multiplier,
    input  logic [N*W-1:0] mod,
    input  logic [N*W-1:0] acc_in,
    output logic [N*W-1:0] mul_out,
    output logic           mul_done,
    output logic           busy,
    output logic           arr_req,
    output logic [W-1:0]   arr_s,
    output logic [N*W-1:0] arr_v,
    output logic [N*W-1:0] arr_add,
    input  logic [N*W-1:0] arr_res,
    output logic [2:0]     dbg_state_o
);

    localparam int NW = N * W;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [CW-1:0] WAIT_INIT = CW'(LAT - 1);
    localparam logic [CW-1:0] WAIT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SCAN = 3'd1,
        S_RED  = 3'd2,
        S_MAC  = 3'd3,
        S_WAIT = 3'd4,
        S_FIN  = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [NW-1:0]   a_q, b_q, g_q, acc_q;
    logic            acc_en_q;
    logic [NW-1:0]   c_q, c_d;
    logic [IW-1:0]   i_q, i_d;
    logic [IW-1:0]   d_q, d_d;
    logic            ret_mac_q, ret_mac_d;   // 1: pass came from RED, resume in MAC
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic [NW-1:0]   mul_out_q, mul_out_d;

    logic            accept;
    logic            next_go;
    logic [NW-1:0]   c_next;
    logic [W-1:0]    b_i;
    logic [W-1:0]    c_top;
    logic [NW-1:0]   c_shift;
    logic [NW-1:0]   acc_mask;
    logic [IW-1:0]   d_scan;
    logic            b_zero;
    logic            red_pass, mac_pass;
    logic            use_red, use_mac;

    // Highest nonzero coefficient of B; the last match in ascending order wins.
    always_comb begin
        d_scan = '0;
        b_zero = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (b_q[k*W +: W] != '0) begin
                d_scan = IW'(k);
                b_zero = 1'b0;
            end
        end
    end

    always_comb begin
        b_i = '0;
        for (int k = 0; k < N; k++) begin
            if (i_q == IW'(k)) b_i = b_q[k*W +: W];
        end
    end

    assign c_top    = c_q[NW-1 -: W];
    assign c_shift  = {c_q[NW-W-1:0], {W{1'b0}}};
    assign acc_mask = acc_en_q ? acc_q : '0;
    // At i = d the accumulator is still zero, so the reduction is skipped.
    assign red_pass = (i_q != d_q) && (c_top != '0);
    assign mac_pass = (b_i != '0);

    // Operands are derived from registers that do not change while a pass is
    // in flight (C is only written at the capture edge), so they stay stable.
    assign use_red = (state_q == S_RED) || ((state_q == S_WAIT) && ret_mac_q);
    assign use_mac = (state_q == S_MAC) || ((state_q == S_WAIT) && !ret_mac_q);

    always_comb begin
        arr_s   = '0;
        arr_v   = '0;
        arr_add = '0;
        if (use_red) begin
            arr_s   = c_top;
            arr_v   = g_q;
            arr_add = c_shift;
        end else if (use_mac) begin
            arr_s   = b_i;
            arr_v   = a_q;
            arr_add = c_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        i_d       = i_q;
        d_d       = d_q;
        ret_mac_d = ret_mac_q;
        wcnt_d    = wcnt_q;
        mul_out_d = mul_out_q;
        arr_req   = 1'b0;
        accept    = 1'b0;
        next_go   = 1'b0;
        c_next    = c_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                c_d = '0;
                if (b_zero) begin
                    mul_out_d = acc_mask;
                    state_d   = S_FIN;
                end else begin
                    i_d     = d_scan;
                    d_d     = d_scan;
                    state_d = S_RED;
                end
            end
            S_RED: begin
                if (red_pass) begin
                    arr_req   = 1'b1;
                    ret_mac_d = 1'b1;
                    wcnt_d    = WAIT_INIT;
                    state_d   = S_WAIT;
                end else begin
                    c_d     = c_shift;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (mac_pass) begin
                    arr_req   = 1'b1;
                    ret_mac_d = 1'b0;
                    wcnt_d    = WAIT_INIT;
                    state_d   = S_WAIT;
                end else begin
                    next_go = 1'b1;
                    c_next  = c_q;
                end
            end
            S_WAIT: begin
                if (wcnt_q == '0) begin
                    c_d = arr_res;
                    if (ret_mac_q) begin
                        state_d = S_MAC;
                    end else begin
                        next_go = 1'b1;
                        c_next  = arr_res;
                    end
                end else begin
                    wcnt_d = wcnt_q - WAIT_ONE;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // NEXT step, shared by MAC without a pass and by WAIT returning from MAC.
        if (next_go) begin
            if (i_q == '0) begin
                mul_out_d = c_next ^ acc_mask;
                state_d   = S_FIN;
            end else begin
                i_d     = i_q - IDX_ONE;
                state_d = S_RED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            g_q       <= '0;
            acc_q     <= '0;
            acc_en_q  <= 1'b0;
            c_q       <= '0;
            i_q       <= '0;
            d_q       <= '0;
            ret_mac_q <= 1'b0;
            wcnt_q    <= '0;
            mul_out_q <= '0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            i_q       <= i_d;
            d_q       <= d_d;
            ret_mac_q <= ret_mac_d;
            wcnt_q    <= wcnt_d;
            mul_out_q <= mul_out_d;
            if (accept) begin
                a_q      <= multiplicand;
                b_q      <= multiplier;
                g_q      <= mod;
                acc_q    <= acc_in;
                acc_en_q <= acc_en;
            end
        end
    end

    assign mul_out     = mul_out_q;
    assign mul_done    = (state_q == S_FIN);
    assign busy        = (state_q != S_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gopf_poly_mul_ctrl.sv
module tb_gopf_poly_mul_ctrl;

    localparam int N  = 9;
    localparam int W  = 16;
    localparam int NW = N * W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_b = 1'b1;
    logic          start1, start3, acc_en;
    logic [NW-1:0] mcand, mplier, modp, accin;

    logic [NW-1:0] mul_out1, v1, add1, res1;
    logic          done1, busy1, req1;
    logic [W-1:0]  s1;
    logic [2:0]    st1;
    logic [NW-1:0] mul_out3, v3, add3, res3;
    logic          done3, busy3, req3;
    logic [W-1:0]  s3;
    logic [2:0]    st3;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int t0    = 0;
    logic [NW-1:0] exp_q1[$];
    logic [NW-1:0] exp_q3[$];
    logic [W-1:0]  rs_q[$];
    logic [NW-1:0] rv_q[$];

    gopf_poly_mul_ctrl #(.N(N), .W(W), .LAT(1)) dut1 (
        .clk(clk), .rst_b(rst_b), .start(start1), .acc_en(acc_en),
        .multiplicand(mcand), .multiplier(mplier), .mod(modp), .acc_in(accin),
        .mul_out(mul_out1), .mul_done(done1), .busy(busy1), .arr_req(req1),
        .arr_s(s1), .arr_v(v1), .arr_add(add1), .arr_res(res1), .dbg_state_o(st1)
    );

    gopf_poly_mul_ctrl #(.N(N), .W(W), .LAT(3)) dut3 (
        .clk(clk), .rst_b(rst_b), .start(start3), .acc_en(acc_en),
        .multiplicand(mcand), .multiplier(mplier), .mod(modp), .acc_in(accin),
        .mul_out(mul_out3), .mul_done(done3), .busy(busy3), .arr_req(req3),
        .arr_s(s3), .arr_v(v3), .arr_add(add3), .arr_res(res3), .dbg_state_o(st3)
    );

    // ---------------- field arithmetic / reference model ----------------
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        logic [W-1:0] xx;
        r  = '0;
        xx = x;
        for (int k = 0; k < W; k++) begin
            if (y[k]) r = r ^ xx;
            xx = xx[W-1] ? ((xx << 1) ^ 16'h100B) : (xx << 1);
        end
        return r;
    endfunction

    function automatic logic [NW-1:0] arr_f(input logic [W-1:0] s, input logic [NW-1:0] v,
                                            input logic [NW-1:0] add);
        logic [NW-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = gf_mul(s, v[k*W +: W]) ^ add[k*W +: W];
        return r;
    endfunction

    // Full schoolbook product, then top-down reduction with x^N = mod(x).
    function automatic logic [NW-1:0] model_mulmod(input logic [NW-1:0] a, input logic [NW-1:0] b,
                                                   input logic [NW-1:0] g);
        logic [W-1:0]  p[2*N-1];
        logic [W-1:0]  t;
        logic [NW-1:0] r;
        for (int k = 0; k < 2*N-1; k++) p[k] = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                p[i+j] = p[i+j] ^ gf_mul(a[i*W +: W], b[j*W +: W]);
        for (int k = 2*N-2; k >= N; k--) begin
            t    = p[k];
            p[k] = '0;
            for (int j = 0; j < N; j++) p[k-N+j] = p[k-N+j] ^ gf_mul(t, g[j*W +: W]);
        end
        for (int k = 0; k < N; k++) r[k*W +: W] = p[k];
        return r;
    endfunction

    function automatic logic [NW-1:0] rand_vec();
        logic [NW-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = W'($urandom_range(0, 65535));
        return r;
    endfunction

    // ---------------- MAC array models (result only valid after LAT cycles) --------
    logic [NW-1:0] p1;
    logic [NW-1:0] p3[3];
    always @(posedge clk) begin
        p1    <= req1 ? arr_f(s1, v1, add1) : '1;
        p3[0] <= req3 ? arr_f(s3, v3, add3) : '1;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign res1 = p1;
    assign res3 = p3[2];

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [511:0] act, input logic [511:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [511:0] pack_outs(input bit u3);
        logic [511:0] r;
        r = '0;
        if (u3) r[453:0] = {mul_out3, done3, busy3, req3, s3, v3, add3, st3};
        else    r[453:0] = {mul_out1, done1, busy1, req1, s1, v1, add1, st1};
        return r;
    endfunction

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (done1) begin
            if (exp_q1.size() == 0) begin
                total++; bad++;
                $display("FAIL done1_unexpected: got done at cycle %0d want none", cyc);
            end else check("mul_out1", mul_out1, exp_q1.pop_front());
        end
        if (done3) begin
            if (exp_q3.size() == 0) begin
                total++; bad++;
                $display("FAIL done3_unexpected: got done at cycle %0d want none", cyc);
            end else check("mul_out3", mul_out3, exp_q3.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; drives start in cycle 0 and returns in cycle 1.
    task automatic start_op(input bit u3, input logic [NW-1:0] a, input logic [NW-1:0] b,
                            input logic [NW-1:0] g, input logic [NW-1:0] c, input logic ae,
                            input logic [NW-1:0] expv, input bit push, input bit scr);
        mcand = a; mplier = b; modp = g; accin = c; acc_en = ae;
        if (u3) start3 = 1'b1; else start1 = 1'b1;
        t0 = cyc;
        if (push) begin
            if (u3) exp_q3.push_back(expv); else exp_q1.push_back(expv);
        end
        @(posedge clk); #1;
        start1 = 1'b0;
        start3 = 1'b0;
        if (scr) begin
            mcand = rand_vec(); mplier = rand_vec(); modp = rand_vec(); accin = rand_vec();
            acc_en = ~ae;
        end
    endtask

    // Records per-cycle req/done/busy bitmaps (bit = cycle since start) and whether
    // pass operands stayed constant for LAT cycles after each arr_req.
    task automatic trace(input bit u3, input logic [31:0] smask, input int ncyc,
                         output logic [31:0] reqm, output logic [31:0] donem,
                         output logic [31:0] busym, output bit held);
        int rel;
        int lat;
        int last_req;
        logic [W-1:0]  hs;
        logic [NW-1:0] hv, ha;
        reqm = '0; donem = '0; busym = '0; held = 1'b1;
        lat = u3 ? 3 : 1;
        last_req = -100;
        hs = '0; hv = '0; ha = '0;
        rs_q.delete();
        rv_q.delete();
        for (int n = 0; n < ncyc; n++) begin
            rel = cyc - t0;
            if (u3) start3 = smask[rel]; else start1 = smask[rel];
            @(negedge clk);
            if (u3 ? req3 : req1) begin
                reqm[rel] = 1'b1;
                hs = u3 ? s3 : s1;
                hv = u3 ? v3 : v1;
                ha = u3 ? add3 : add1;
                rs_q.push_back(hs);
                rv_q.push_back(hv);
                last_req = rel;
            end else if ((rel - last_req) >= 1 && (rel - last_req) <= lat) begin
                if (u3 ? ({s3, v3, add3} !== {hs, hv, ha}) : ({s1, v1, add1} !== {hs, hv, ha}))
                    held = 1'b0;
            end
            if (u3 ? done3 : done1) donem[rel] = 1'b1;
            if (u3 ? busy3 : busy1) busym[rel] = 1'b1;
            @(posedge clk); #1;
        end
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_done(input bit u3, input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (u3 ? done3 : done1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: got no done within 200 cycles want done", name);
        end
        @(posedge clk); #1;
    endtask

    // ---------------- test ----------------
    typedef struct {
        logic [NW-1:0] a, b, g, c;
        logic          ae;
        logic [NW-1:0] expv;
    } vec_t;

    vec_t vt[13];

    initial begin : main
        logic [31:0]   reqm, donem, busym;
        bit            held;
        logic [NW-1:0] a_one, a_x8, b_x, g_x1, x_plus_1, c_beef, tmp;

        start1 = 1'b0; start3 = 1'b0; acc_en = 1'b0;
        mcand = '0; mplier = '0; modp = '0; accin = '0;

        // Asynchronous reset asserted mid-clock, before any edge.
        #2 rst_b = 1'b0;
        #1;
        check("rst_outs_lat1", pack_outs(0), '0);
        check("rst_outs_lat3", pack_outs(1), '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("busy_after_rst", {busy1, busy3}, 2'b00);

        // Shared operands.
        a_one = '0;  a_one[3*W +: W] = 16'h1234;
        a_x8  = '0;  a_x8[8*W +: W]  = 16'h0001;
        b_x   = '0;  b_x[1*W +: W]   = 16'h0001;
        g_x1  = '0;  g_x1[0 +: W] = 16'h0001; g_x1[W +: W] = 16'h0001;
        x_plus_1 = g_x1;
        c_beef = '0; c_beef[4*W +: W] = 16'hBEEF;

        // Vector table.
        vt[0] = '{a: a_one, b: 144'h1, g: rand_vec(), c: rand_vec(), ae: 1'b0, expv: a_one};
        vt[1] = '{a: a_x8, b: b_x, g: g_x1, c: rand_vec(), ae: 1'b0, expv: x_plus_1};
        vt[2] = '{a: rand_vec(), b: '0, g: rand_vec(), c: c_beef, ae: 1'b1, expv: c_beef};
        vt[3] = '{a: '0, b: rand_vec(), g: rand_vec(), c: rand_vec(), ae: 1'b0, expv: '0};
        tmp = rand_vec();
        vt[4] = '{a: '0, b: rand_vec(), g: rand_vec(), c: tmp, ae: 1'b1, expv: tmp};
        for (int k = 5; k < 13; k++) begin
            vt[k].a  = rand_vec();
            vt[k].b  = rand_vec();
            vt[k].g  = rand_vec();
            vt[k].c  = rand_vec();
            vt[k].ae = 1'($urandom_range(0, 1));
        end
        vt[10].b = '0;
        vt[10].b[8*W +: W] = W'($urandom_range(1, 65535));
        for (int k = 0; k < N; k++) vt[11].b[k*W +: W] = W'($urandom_range(1, 65535));
        vt[12].g = '0;
        for (int k = 5; k < 13; k++)
            vt[k].expv = model_mulmod(vt[k].a, vt[k].b, vt[k].g) ^ (vt[k].ae ? vt[k].c : '0);

        // LAT=1, B = 1: single MAC pass in cycle 3, done in cycle 5.
        @(posedge clk); #1;
        start_op(0, a_one, 144'h1, '0, '0, 1'b0, a_one, 1, 1);
        trace(0, 32'h0, 8, reqm, donem, busym, held);
        check("b1_req_cycles", reqm, 32'h0000_0008);
        check("b1_done_cycles", donem, 32'h0000_0020);
        check("b1_busy_cycles", busym, 32'h0000_003E);
        if (rs_q.size() > 0) begin
            check("b1_arr_s", rs_q[0], 16'h0001);
            check("b1_arr_v", rv_q[0], a_one);
        end

        // LAT=1 reduction: passes in cycles 3 and 5, b0 MAC skipped, done in 8.
        start_op(0, a_x8, b_x, g_x1, '0, 1'b0, x_plus_1, 1, 1);
        trace(0, 32'h0, 10, reqm, donem, busym, held);
        check("red_req_cycles", reqm, 32'h0000_0028);
        check("red_done_cycles", donem, 32'h0000_0100);
        check("red_busy_cycles", busym, 32'h0000_01FE);
        if (rs_q.size() > 1) begin
            check("red_arr_s", rs_q[1], 16'h0001);
            check("red_arr_v", rv_q[1], g_x1);
        end

        // B = 0 with accumulate; start held through cycle 3 is re-accepted only in IDLE.
        start_op(0, rand_vec(), '0, rand_vec(), c_beef, 1'b1, c_beef, 1, 0);
        exp_q1.push_back(c_beef);
        trace(0, 32'h0000_000E, 7, reqm, donem, busym, held);
        check("b0_req_cycles", reqm, 32'h0);
        check("b0_done_cycles", donem, 32'h0000_0024);
        check("b0_busy_cycles", busym, 32'h0000_0036);

        // LAT=3, B = 1: operands held cycles 3..6, done in 7, start in cycle 4 ignored.
        start_op(1, a_one, 144'h1, '0, '0, 1'b0, a_one, 1, 1);
        trace(1, 32'h0000_0010, 7, reqm, donem, busym, held);
        check("l3_req_cycles", reqm, 32'h0000_0008);
        check("l3_done_cycles", donem, 32'h0000_0080);
        check("l3_busy_cycles", busym, 32'h0000_00FE);
        check("l3_ops_held", held, 1'b1);
        // Cycle 8 of the previous run: a fresh start is accepted.
        tmp = '0; tmp[0 +: W] = 16'h00AB; tmp[8*W +: W] = 16'h5555;
        start_op(1, tmp, 144'h1, rand_vec(), '0, 1'b0, tmp, 1, 1);
        trace(1, 32'h0, 8, reqm, donem, busym, held);
        check("l3_rerun_req", reqm, 32'h0000_0008);
        check("l3_rerun_done", donem, 32'h0000_0080);

        // LAT=3 reduction with accumulate.
        start_op(1, a_x8, b_x, g_x1, c_beef, 1'b1, x_plus_1 ^ c_beef, 1, 1);
        wait_done(1, "l3_red_done");

        // Asynchronous reset during WAIT of the reduction case aborts the run.
        start_op(0, a_x8, b_x, g_x1, '0, 1'b0, x_plus_1, 1, 1);
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        rst_b = 1'b0;
        #1;
        check("abort_outs", pack_outs(0), '0);
        exp_q1.delete();
        @(posedge clk); #1;
        rst_b = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_idle", busy1, 1'b0);
        start_op(0, a_x8, b_x, g_x1, '0, 1'b0, x_plus_1, 1, 1);
        wait_done(0, "abort_rerun_done");

        // Table-driven vectors on the LAT=1 instance.
        for (int k = 0; k < 13; k++) begin
            start_op(0, vt[k].a, vt[k].b, vt[k].g, vt[k].c, vt[k].ae, vt[k].expv, 1, 1);
            wait_done(0, $sformatf("vec%0d_done", k));
        end

        repeat (4) @(posedge clk);
        #1;
        check("q1_drained", exp_q1.size(), 0);
        check("q3_drained", exp_q3.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
